// File: rtl/blram_loader.sv
// ---------------------------------------------------------------------------
// blram_loader
//
// Byte-stream loader for the 16-bit block RAM write port. Bytes arrive over a
// valid/ready handshake, are packed in pairs (first byte = low byte) into
// 16-bit words and written to consecutive RAM addresses starting at a base
// address. o_busy covers the whole transfer so the CPU can be kept off the
// RAM. Every output is registered.
//
// Optional feature (compile-time macro LOADER_CHECKSUM_EN):
//   An 8-bit running sum of all accepted data bytes is kept. After the last
//   word one extra byte is accepted and compared against that sum; a
//   difference raises o_err. With the macro undefined there is neither a
//   checksum state nor a sum register.
//
// Parameters
//   SIZE   RAM address width (must match the RAM)
//   DEPTH  RAM depth in words (must equal 2**SIZE)
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous reset, active low
//   i_start        in   one-cycle pulse starting a load (ignored while busy)
//   i_base_addr    in   first word address, sampled on i_start
//   i_word_count   in   number of words to load (0..DEPTH), sampled on i_start
//   i_byte_valid   in   upstream byte valid
//   i_byte         in   upstream byte
//   o_byte_ready   out  loader accepts a byte this cycle
//   o_we           out  RAM write enable (one cycle per word)
//   o_addr         out  RAM word address
//   o_ram_data_in  out  RAM write data
//   o_busy         out  load in progress
//   o_done         out  one-cycle pulse at the end of a load
//   o_err          out  sticky error (address wrap / checksum), cleared by
//                       the next accepted i_start
// ---------------------------------------------------------------------------
module blram_loader #(
  parameter int SIZE  = 13,
  parameter int DEPTH = 8192
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [SIZE-1:0] i_base_addr,
  input  logic [SIZE:0]   i_word_count,
  input  logic            i_byte_valid,
  input  logic [7:0]      i_byte,
  output logic            o_byte_ready,
  output logic            o_we,
  output logic [SIZE-1:0] o_addr,
  output logic [15:0]     o_ram_data_in,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err
);

  // Highest word address; reaching it with words still to go means the next
  // address wraps to zero.
  localparam logic [SIZE-1:0] LAST_ADDR = SIZE'(DEPTH - 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_WR   = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd5
  } state_t;
`endif

  state_t          state_q,    state_d;
  logic [SIZE-1:0] cur_addr_q, cur_addr_d;
  logic [SIZE:0]   count_q,    count_d;
  logic [7:0]      low_q,      low_d;
  logic            ready_q,    ready_d;
  logic            we_q,       we_d;
  logic [SIZE-1:0] addr_q,     addr_d;
  logic [15:0]     data_q,     data_d;
  logic            busy_q,     busy_d;
  logic            done_q,     done_d;
  logic            err_q,      err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      sum_q,      sum_d;
`endif

  logic hs_s;

  // A byte moves when upstream is valid and the registered ready is high.
  assign hs_s = i_byte_valid & ready_q;

  // Next-state and next-output computation for the load sequencer.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    count_d    = count_q;
    low_d      = low_q;
    ready_d    = ready_q;
    we_d       = 1'b0;          // write strobe lasts a single cycle
    addr_d     = addr_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;          // done is a single-cycle pulse
    err_d      = err_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b0;
        if (i_start) begin
          cur_addr_d = i_base_addr;
          count_d    = i_word_count;
          err_d      = 1'b0;
          busy_d     = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = 8'h00;
`endif
          if (i_word_count == (SIZE+1)'(0)) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CSUM;
            ready_d = 1'b1;
`else
            state_d = S_DONE;
            ready_d = 1'b0;
`endif
          end else begin
            state_d = S_LO;
            ready_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LO: begin
        if (hs_s) begin
          low_d   = i_byte;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + i_byte;
`endif
          state_d = S_HI;
        end else begin
          state_d = S_LO;
        end
      end

      S_HI: begin
        if (hs_s) begin
          data_d  = {i_byte, low_q};
          addr_d  = cur_addr_q;
          we_d    = 1'b1;
          ready_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + i_byte;
`endif
          state_d = S_WR;
        end else begin
          state_d = S_HI;
        end
      end

      S_WR: begin
        // The write is on the bus during this cycle; advance the pointer.
        cur_addr_d = cur_addr_q + SIZE'(1);
        count_d    = count_q - (SIZE+1)'(1);
        if (count_q != (SIZE+1)'(1)) begin
          state_d = S_LO;
          ready_d = 1'b1;
          // More words to come but the address is about to roll over.
          if (cur_addr_q == LAST_ADDR) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CSUM;
          ready_d = 1'b1;
`else
          state_d = S_DONE;
          ready_d = 1'b0;
`endif
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (hs_s) begin
          if (i_byte != sum_q) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          ready_d = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_CSUM;
        end
      end
`endif

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cur_addr_q <= {SIZE{1'b0}};
      count_q    <= {(SIZE+1){1'b0}};
      low_q      <= 8'h00;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= {SIZE{1'b0}};
      data_q     <= 16'h0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      count_q    <= count_d;
      low_q      <= low_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign o_byte_ready  = ready_q;
  assign o_we          = we_q;
  assign o_addr        = addr_q;
  assign o_ram_data_in = data_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err         = err_q;

endmodule
